// File: rtl/usart_tx_scheduler_if.sv
// usart_tx_scheduler_if: requester and transmitter-FSM signals of the shared USART TX scheduler
interface usart_tx_scheduler_if #(
   parameter int NREQ = 2,
   parameter int DW   = 9
);
   logic              i_TXEN;
   logic              i_txclk;
   logic [NREQ-1:0]   i_req;
   logic [NREQ*DW-1:0] i_data;
   logic [NREQ*5-1:0] i_cfg;
   logic              i_fsm_we;
   logic              i_txc;
   logic [NREQ-1:0]   o_gnt;
   logic [DW-1:0]     o_udr;
   logic              o_udre;
   logic [2:0]        o_ucsz;
   logic              o_usbs;
   logic              o_upm1;
   logic [NREQ-1:0]   o_done;
   logic              o_busy;
   modport master (
      output i_TXEN, i_txclk, i_req, i_data, i_cfg, i_fsm_we, i_txc,
      input  o_gnt, o_udr, o_udre, o_ucsz, o_usbs, o_upm1, o_done, o_busy
   );
   modport slave (
      input  i_TXEN, i_txclk, i_req, i_data, i_cfg, i_fsm_we, i_txc,
      output o_gnt, o_udr, o_udre, o_ucsz, o_usbs, o_upm1, o_done, o_busy
   );
endinterface

// File: rtl/usart_tx_scheduler.sv
// usart_tx_scheduler: round-robin sharing of one USART transmitter buffer among NREQ requesters
module usart_tx_scheduler #(
   parameter int NREQ = 2,
   parameter int DW   = 9
) (
   input logic                 i_fosk,
   input logic                 i_rst_n,
   usart_tx_scheduler_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   logic            buf_full, act_vld;
   logic [DW-1:0]   buf_data;
   logic [4:0]      buf_cfg, act_cfg;
   logic [PW-1:0]   buf_own, act_own, rr_ptr, win;
   logic [NREQ-1:0] gnt_q, done_q;
   logic            consume, complete, grant;
   assign consume  = bus.i_fsm_we & bus.i_txclk & buf_full;
   assign complete = bus.i_txc & bus.i_txclk & act_vld;
   assign grant    = ~buf_full & bus.i_TXEN & (|bus.i_req);
   // pick the first requester at or after rr_ptr; scanning downward lets the nearest one win
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (bus.i_req[(int'(rr_ptr) + i) % NREQ]) win = PW'((int'(rr_ptr) + i) % NREQ);
   end
   // buffer, active-frame and pointer state; consume outranks complete so only one done pulses
   always_ff @(posedge i_fosk) begin
      if (!i_rst_n) begin
         buf_full <= 1'b0;
         buf_data <= '0;
         buf_cfg  <= '0;
         buf_own  <= '0;
         act_vld  <= 1'b0;
         act_cfg  <= 5'b011_0_0;
         act_own  <= '0;
         rr_ptr   <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         if (grant) begin
            buf_full <= 1'b1;
            buf_data <= bus.i_data[int'(win)*DW +: DW];
            buf_cfg  <= bus.i_cfg[int'(win)*5 +: 5];
            buf_own  <= win;
            gnt_q    <= NREQ'(1) << win;
            rr_ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
         end
         if (consume) begin
            buf_full <= 1'b0;
            act_vld  <= 1'b1;
            act_cfg  <= buf_cfg;
            act_own  <= buf_own;
            if (act_vld) done_q <= NREQ'(1) << act_own;
         end else if (complete) begin
            act_vld <= 1'b0;
            done_q  <= NREQ'(1) << act_own;
         end
      end
   end
   assign bus.o_gnt  = gnt_q;
   assign bus.o_done = done_q;
   assign bus.o_udre = ~buf_full;
   assign bus.o_udr  = buf_data;
   assign {bus.o_ucsz, bus.o_usbs, bus.o_upm1} = act_cfg;
   assign bus.o_busy = buf_full | act_vld;
endmodule
